// File: rtl/bcd_scoreboard_pkg.sv
// Shared types and helpers for the BCD match scoreboard: FSM states,
// active-low 7-segment patterns (bit order {g,f,e,d,c,b,a}) and BCD conversion.
package scoreboard_pkg;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Non-BCD codes cannot occur in a score; they fall back to "0".
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

  function automatic logic [15:0] dec_to_bcd(input int unsigned value);
    logic [15:0] bcd;
    int unsigned rest;
    bcd  = '0;
    rest = value;
    for (int d = 0; d < 4; d++) begin
      bcd[d*4 +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bcd_scoreboard_if.sv
// Bus bundle for bcd_scoreboard: match controls in, scores, segments and
// match status out. master drives the controls, slave is the scoreboard.
interface bcd_scoreboard_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DIGITS  = 2
);
  localparam int WID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                                enable;
  logic                                score_clr;
  logic [NUM_PLAYERS-1:0]              point_req;
  logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] scores_bcd;
  logic [NUM_PLAYERS*NUM_DIGITS*7-1:0] seg_n;
  logic                                match_over;
  logic [WID_W-1:0]                    winner_id;

  modport master (
    output enable, score_clr, point_req,
    input  scores_bcd, seg_n, match_over, winner_id
  );

  modport slave (
    input  enable, score_clr, point_req,
    output scores_bcd, seg_n, match_over, winner_id
  );
endinterface

// File: rtl/bcd_scoreboard_bcd_digit_cnt.sv
// One BCD digit of a score counter. digit_next is exposed so the parent can
// compare the upcoming score in the same cycle it is registered.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  always_comb begin
    digit_next = digit;
    if (clr) begin
      digit_next = 4'd0;
    end else if (inc_in) begin
      digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

  assign carry_out = inc_in & (digit == 4'd9);

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      digit <= 4'd0;
    end else begin
      digit <= digit_next;
    end
  end

endmodule

// File: rtl/bcd_scoreboard.sv
// Multi-player BCD match scoreboard with first-to-WIN_SCORE detection and
// active-low 7-segment drive. Define SCORE_BLANK_EN for leading-zero blanking.
module bcd_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DIGITS  = 2,
  parameter int WIN_SCORE   = 10
) (
  input logic              clk,
  input logic              clear_b,
  bcd_scoreboard_if.slave  bus
);

  localparam int NUM_CELLS = NUM_PLAYERS * NUM_DIGITS;
  localparam int SCORE_W   = NUM_DIGITS * 4;
  localparam int WID_W     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [15:0]        WIN_BCD_ALL = dec_to_bcd(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_BCD     = WIN_BCD_ALL[SCORE_W-1:0];

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_size
    $error("bcd_scoreboard: NUM_PLAYERS must be 1..8 and NUM_DIGITS 1..4");
  end
  if (WIN_SCORE < 0 || WIN_SCORE >= 10**NUM_DIGITS) begin : g_bad_win
    $error("bcd_scoreboard: WIN_SCORE does not fit in NUM_DIGITS digits");
  end

  state_t                 state, state_next;
  logic [WID_W-1:0]       winner, winner_next;
  logic [NUM_PLAYERS-1:0] prev, hit, inc_en;
  wire  [NUM_CELLS*4-1:0] score_q, score_d;
  wire  [NUM_CELLS*7-1:0] seg_all;
  wire  [NUM_CELLS-1:0]   carry, inc_chain;
  wire  [NUM_PLAYERS-1:0] unused_wrap;

  // History resets to all ones so a button held through reset is not a new press.
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      prev <= '1;
    end else begin
      prev <= bus.point_req;
    end
  end

  assign hit    = bus.point_req & ~prev;
  assign inc_en = (state == PLAY && bus.enable) ? hit : '0;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      localparam int IDX = p*NUM_DIGITS + d;
      wire [6:0] digit_seg;

      if (d == 0) begin : g_lsd
        assign inc_chain[IDX] = inc_en[p];
      end else begin : g_upper
        assign inc_chain[IDX] = carry[IDX-1];
      end

      bcd_digit_cnt u_digit (
        .clk        (clk),
        .clear_b    (clear_b),
        .clr        (bus.score_clr),
        .inc_in     (inc_chain[IDX]),
        .digit      (score_q[IDX*4 +: 4]),
        .digit_next (score_d[IDX*4 +: 4]),
        .carry_out  (carry[IDX])
      );

      assign digit_seg = bcd_to_seg(score_q[IDX*4 +: 4]);

`ifdef SCORE_BLANK_EN
      if (d > 0) begin : g_blank
        assign seg_all[IDX*7 +: 7] =
          (score_q[(p+1)*SCORE_W-1 : IDX*4] == '0) ? SEG_BLANK : digit_seg;
      end else begin : g_keep
        assign seg_all[IDX*7 +: 7] = digit_seg;
      end
`else
      assign seg_all[IDX*7 +: 7] = digit_seg;
`endif
    end

    // All-9s wraps silently; the top carry goes nowhere.
    assign unused_wrap[p] = carry[p*NUM_DIGITS + NUM_DIGITS - 1];
  end

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      state  <= PLAY;
      winner <= '0;
    end else begin
      state  <= state_next;
      winner <= winner_next;
    end
  end

  // Scan from the top index down so the lowest matching player wins a tie.
  always_comb begin
    state_next  = state;
    winner_next = winner;
    if (bus.score_clr) begin
      state_next  = PLAY;
      winner_next = '0;
    end else if (state == PLAY && WIN_SCORE != 0) begin
      for (int p = NUM_PLAYERS-1; p >= 0; p--) begin
        if (score_d[p*SCORE_W +: SCORE_W] == WIN_BCD) begin
          state_next  = OVER;
          winner_next = WID_W'(p);
        end
      end
    end
  end

  assign bus.scores_bcd = score_q;
  assign bus.seg_n      = seg_all;
  assign bus.match_over = (state == OVER);
  assign bus.winner_id  = winner;

endmodule

// File: tb/tb_bcd_scoreboard.sv
// Scoreboard bench for bcd_scoreboard: one DUT with WIN_SCORE=10 and one
// free-running (WIN_SCORE=0) share the stimulus and a decimal reference model.
module tb_bcd_scoreboard;

  localparam int NP    = 2;
  localparam int ND    = 2;
  localparam int WID_W = 1;
  localparam int SC_W  = NP*ND*4;
  localparam int SG_W  = NP*ND*7;
  localparam int LIMIT = 100;

  typedef struct packed {
    logic [SC_W-1:0]  sc0, sc1;
    logic [SG_W-1:0]  sg0, sg1;
    logic             ov0, ov1;
    logic [WID_W-1:0] wn0, wn1;
  } expect_t;

  logic          clk;
  logic          clear_b;
  logic          enable;
  logic          score_clr;
  logic [NP-1:0] point_req;

  int checks = 0;
  int errors = 0;

  expect_t       exp_q[$];
  int            m_score [2][NP];
  bit            m_over  [2];
  int            m_winner[2];
  logic [NP-1:0] m_prev;
  logic [6:0]    seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_scoreboard_if #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND)) bus_win ();
  bcd_scoreboard_if #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND)) bus_free ();

  assign bus_win.enable     = enable;
  assign bus_win.score_clr  = score_clr;
  assign bus_win.point_req  = point_req;
  assign bus_free.enable    = enable;
  assign bus_free.score_clr = score_clr;
  assign bus_free.point_req = point_req;

  bcd_scoreboard #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .WIN_SCORE(10)) dut_win (
    .clk     (clk),
    .clear_b (clear_b),
    .bus     (bus_win)
  );

  bcd_scoreboard #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .WIN_SCORE(0)) dut_free (
    .clk     (clk),
    .clear_b (clear_b),
    .bus     (bus_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int win_of(input int k);
    return (k == 0) ? 10 : 0;
  endfunction

  function automatic int pow10(input int d);
    int r = 1;
    repeat (d) r = r * 10;
    return r;
  endfunction

  function automatic logic [SC_W-1:0] pack_scores(input int k);
    logic [SC_W-1:0] r = '0;
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < ND; d++)
        r[(p*ND+d)*4 +: 4] = 4'((m_score[k][p] / pow10(d)) % 10);
    return r;
  endfunction

  function automatic logic [SG_W-1:0] pack_segs(input int k);
    logic [SG_W-1:0] r = '0;
    logic [6:0] seg;
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < ND; d++) begin
        seg = seg_tab[(m_score[k][p] / pow10(d)) % 10];
`ifdef SCORE_BLANK_EN
        if (d > 0 && m_score[k][p] < pow10(d)) seg = 7'h7F;
`endif
        r[(p*ND+d)*7 +: 7] = seg;
      end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push what both DUTs must show after the next edge.
  task automatic applyStimulus(input logic rst_b, input logic en, input logic clr,
                               input logic [NP-1:0] req);
    logic [NP-1:0] hit;
    expect_t e;
    @(negedge clk);
    clear_b   = rst_b;
    enable    = en;
    score_clr = clr;
    point_req = req;
    if (!rst_b) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < NP; p++) m_score[k][p] = 0;
        m_over[k]   = 1'b0;
        m_winner[k] = 0;
      end
      m_prev = '1;
    end else begin
      hit    = req & ~m_prev;
      m_prev = req;
      for (int k = 0; k < 2; k++) begin
        if (clr) begin
          for (int p = 0; p < NP; p++) m_score[k][p] = 0;
          m_over[k]   = 1'b0;
          m_winner[k] = 0;
        end else if (!m_over[k]) begin
          for (int p = 0; p < NP; p++)
            if (hit[p] && en) m_score[k][p] = (m_score[k][p] + 1) % LIMIT;
          if (win_of(k) != 0)
            for (int p = 0; p < NP; p++)
              if (!m_over[k] && m_score[k][p] == win_of(k)) begin
                m_over[k]   = 1'b1;
                m_winner[k] = p;
              end
        end
      end
    end
    e.sc0 = pack_scores(0);
    e.sc1 = pack_scores(1);
    e.sg0 = pack_segs(0);
    e.sg1 = pack_segs(1);
    e.ov0 = m_over[0];
    e.ov1 = m_over[1];
    e.wn0 = WID_W'(m_winner[0]);
    e.wn1 = WID_W'(m_winner[1]);
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [NP-1:0] mask, input logic en, input int n);
    repeat (n) begin
      applyStimulus(1'b1, en, 1'b0, mask);
      applyStimulus(1'b1, en, 1'b0, '0);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge that follows a pushed stimulus is compared against the model.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("win.scores", 64'(bus_win.scores_bcd), 64'(e.sc0));
        checkOutput("win.seg_n",  64'(bus_win.seg_n),      64'(e.sg0));
        checkOutput("win.over",   64'(bus_win.match_over), 64'(e.ov0));
        checkOutput("win.winner", 64'(bus_win.winner_id),  64'(e.wn0));
        checkOutput("free.scores", 64'(bus_free.scores_bcd), 64'(e.sc1));
        checkOutput("free.seg_n",  64'(bus_free.seg_n),      64'(e.sg1));
        checkOutput("free.over",   64'(bus_free.match_over), 64'(e.ov1));
        checkOutput("free.winner", 64'(bus_free.winner_id),  64'(e.wn1));
      end
    end
  end

  initial begin
    logic rb, en, clr;
    logic [NP-1:0] req;
    clear_b   = 1'b0;
    enable    = 1'b1;
    score_clr = 1'b0;
    point_req = '0;

    // Reset with player 0 held, then 3 clean presses.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 2'b01);
    sample();
    checkOutput("held_through_reset", 64'(bus_win.scores_bcd), 64'h0000);
    checkOutput("reset_over", 64'(bus_win.match_over), 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    pulse(2'b01, 1'b1, 3);
    sample();
    checkOutput("three_presses", 64'(bus_win.scores_bcd), 64'h0003);
    checkOutput("seg_digit0_3", 64'(bus_win.seg_n[6:0]), 64'(7'b0110000));

    // Player 1 climbs to 09, then 10 wins.
    pulse(2'b10, 1'b1, 9);
    sample();
    checkOutput("p1_at_9", 64'(bus_win.scores_bcd), 64'h0903);
    pulse(2'b10, 1'b1, 1);
    sample();
    checkOutput("p1_wins_score", 64'(bus_win.scores_bcd), 64'h1003);
    checkOutput("p1_wins_over", 64'(bus_win.match_over), 64'h1);
    checkOutput("p1_wins_id", 64'(bus_win.winner_id), 64'h1);
    checkOutput("free_no_over", 64'(bus_free.match_over), 64'h0);
    pulse(2'b11, 1'b1, 3);
    sample();
    checkOutput("frozen_after_win", 64'(bus_win.scores_bcd), 64'h1003);

    // Simultaneous 09 -> 10 tie goes to player 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    pulse(2'b11, 1'b1, 9);
    pulse(2'b11, 1'b1, 1);
    sample();
    checkOutput("tie_scores", 64'(bus_win.scores_bcd), 64'h1010);
    checkOutput("tie_over", 64'(bus_win.match_over), 64'h1);
    checkOutput("tie_id", 64'(bus_win.winner_id), 64'h0);

    // Free-running instance wraps 99 -> 00.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    pulse(2'b01, 1'b1, 99);
    sample();
    checkOutput("free_99", 64'(bus_free.scores_bcd[7:0]), 64'h99);
    pulse(2'b01, 1'b1, 1);
    sample();
    checkOutput("free_wrap", 64'(bus_free.scores_bcd[7:0]), 64'h00);
    checkOutput("free_wrap_over", 64'(bus_free.match_over), 64'h0);

    // Disabled presses are dropped; a request held across enable 0->1 does not score.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
    pulse(2'b01, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    sample();
    checkOutput("disabled_drop", 64'(bus_win.scores_bcd), 64'h0000);

    // Clear in the same cycle as a press while OVER.
    pulse(2'b10, 1'b1, 10);
    sample();
    checkOutput("over_before_clr", 64'(bus_win.match_over), 64'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    sample();
    checkOutput("clr_scores", 64'(bus_win.scores_bcd), 64'h0000);
    checkOutput("clr_over", 64'(bus_win.match_over), 64'h0);
    checkOutput("clr_free_scores", 64'(bus_free.scores_bcd), 64'h0000);

    // Randomised play with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      rb  = ($urandom_range(0, 299) != 0);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 79) == 0);
      req = NP'($urandom_range(0, 3));
      applyStimulus(rb, en, clr, req);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
